// File: rtl/tmds_decoder_align_if.sv
// Bus between a 1:10 deserializer channel and its TMDS word aligner/decoder.
// The deserializer side drives the raw words; the decoder returns pixel, control and lock status.
interface tmds_decoder_align_if;
   logic [9:0] din;
   logic [7:0] dout;
   logic       c0;
   logic       c1;
   logic       vde;
   logic       locked;
   logic [3:0] bit_offset;

   modport master (output din, input dout, c0, c1, vde, locked, bit_offset);
   modport slave  (input din, output dout, c0, c1, vde, locked, bit_offset);
endinterface

// File: rtl/tmds_decoder_align.sv
// TMDS receive channel: finds the 10-bit word boundary from runs of control tokens,
// then decodes TMDS words back to 8-bit pixel data, c0/c1 and vde.
module tmds_decoder_align #(
   parameter int unsigned CTRL_RUN  = 16,
   parameter int unsigned TIMEOUT_W = 22
) (
   input  logic                 pix_clk,
   input  logic                 rst_n,
   tmds_decoder_align_if.slave  bus
);

   localparam int unsigned      RUN_W   = $clog2(CTRL_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(CTRL_RUN);
   localparam logic [3:0]       OFF_MAX = 4'd9;

   typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_e;

   state_e               state_q, state_d;
   logic [9:0]           din_d_q;
   logic [9:0]           w_q, w_d;
   logic [3:0]           bit_offset_q, bit_offset_d;
   logic [RUN_W-1:0]     run_cnt_q, run_cnt_d;
   logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;
   logic [1:0]           discard_q, discard_d;
   logic                 locked_q, locked_d;
   logic [7:0]           dout_q, dout_d;
   logic                 c0_q, c0_d;
   logic                 c1_q, c1_d;
   logic                 vde_q, vde_d;

   logic [19:0]          cat;
   logic                 is_ctrl;
   logic [1:0]           ctrl_val;
   logic [7:0]           qx;
   logic [7:0]           dec;
   logic                 hit;
   logic                 wrap;

   // Select the 10-bit window spanning the previous and current raw words.
   always_comb begin
      cat = {bus.din, din_d_q};
      w_d = 10'(cat >> bit_offset_q);
   end

   // Control token classification, {c1,c0} in ctrl_val.
   always_comb begin
      is_ctrl  = 1'b1;
      ctrl_val = 2'b00;
      case (w_q)
         10'h354: ctrl_val = 2'b00;
         10'h0AB: ctrl_val = 2'b01;
         10'h154: ctrl_val = 2'b10;
         10'h2AB: ctrl_val = 2'b11;
         default: is_ctrl  = 1'b0;
      endcase
   end

   // TMDS data decode: undo the optional inversion, then the XOR/XNOR chain.
   always_comb begin
      qx     = w_q[9] ? ~w_q[7:0] : w_q[7:0];
      dec    = '0;
      dec[0] = qx[0];
      for (int i = 1; i < 8; i++) begin
         dec[i] = w_q[8] ? (qx[i] ^ qx[i-1]) : ~(qx[i] ^ qx[i-1]);
      end
   end

   // Run/timeout tracking and lock FSM; a completed run outranks a timeout on the same edge.
   always_comb begin
      state_d      = state_q;
      run_cnt_d    = run_cnt_q;
      to_cnt_d     = to_cnt_q + TIMEOUT_W'(1);
      discard_d    = discard_q;
      bit_offset_d = bit_offset_q;
      hit          = 1'b0;
      wrap         = &to_cnt_q;

      if (discard_q != 2'd0) begin
         discard_d = discard_q - 2'd1;
      end else if (is_ctrl) begin
         run_cnt_d = (run_cnt_q == RUN_MAX) ? run_cnt_q : run_cnt_q + RUN_W'(1);
         hit       = (run_cnt_d == RUN_MAX);
      end else begin
         run_cnt_d = '0;
      end

      unique case (state_q)
         SEARCH: if (hit) state_d = LOCKED;
         LOCKED: if (!hit && wrap) state_d = SEARCH;
         default: state_d = SEARCH;
      endcase

      if (hit) begin
         to_cnt_d = '0;
      end else if (wrap) begin
         bit_offset_d = (bit_offset_q == OFF_MAX) ? 4'd0 : bit_offset_q + 4'd1;
         run_cnt_d    = '0;
         discard_d    = 2'd2;
      end

      locked_d = (state_d == LOCKED);
   end

   // Output formatting follows the lock state that becomes visible on this edge.
   always_comb begin
      dout_d = '0;
      vde_d  = 1'b0;
      c0_d   = c0_q;
      c1_d   = c1_q;
      if (!locked_d) begin
         c0_d = 1'b0;
         c1_d = 1'b0;
      end else if (is_ctrl) begin
         c0_d = ctrl_val[0];
         c1_d = ctrl_val[1];
      end else begin
         vde_d  = 1'b1;
         dout_d = dec;
      end
   end

   always_ff @(posedge pix_clk) begin
      if (!rst_n) begin
         state_q      <= SEARCH;
         din_d_q      <= '0;
         w_q          <= '0;
         bit_offset_q <= '0;
         run_cnt_q    <= '0;
         to_cnt_q     <= '0;
         discard_q    <= '0;
         locked_q     <= 1'b0;
         dout_q       <= '0;
         c0_q         <= 1'b0;
         c1_q         <= 1'b0;
         vde_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         din_d_q      <= bus.din;
         w_q          <= w_d;
         bit_offset_q <= bit_offset_d;
         run_cnt_q    <= run_cnt_d;
         to_cnt_q     <= to_cnt_d;
         discard_q    <= discard_d;
         locked_q     <= locked_d;
         dout_q       <= dout_d;
         c0_q         <= c0_d;
         c1_q         <= c1_d;
         vde_q        <= vde_d;
      end
   end

   assign bus.dout       = dout_q;
   assign bus.c0         = c0_q;
   assign bus.c1         = c1_q;
   assign bus.vde        = vde_q;
   assign bus.locked     = locked_q;
   assign bus.bit_offset = bit_offset_q;

endmodule

// File: tb/tb_tmds_decoder_align.sv
// Bench for tmds_decoder_align: directed lock/slip scenarios plus random token/data traffic,
// every cycle compared against a bit-stream level reference model.
module tb_tmds_decoder_align;

   localparam int CR = 4;
   localparam int TW = 6;

   logic pix_clk;
   logic rst_n;
   tmds_decoder_align_if bus ();

   tmds_decoder_align #(.CTRL_RUN(CR), .TIMEOUT_W(TW)) dut (
      .pix_clk (pix_clk),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   initial pix_clk = 1'b0;
   always #5 pix_clk = ~pix_clk;

   int n_total;
   int n_bad;

   logic [15:0] got;
   assign got = {bus.locked, bus.bit_offset, bus.vde, bus.c1, bus.c0, bus.dout};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model state: raw word history, alignment search and visible outputs.
   int hw_old, hw_new, ho_new;
   int m_off, m_run, m_to, m_skip;
   bit m_locked, m_c0, m_c1, m_vde;
   int m_dout;

   task automatic model_edge(input int w, input bit rst);
      int win, q, d, b, cv;
      bit ctrl, hit, wrap;
      if (!rst) begin
         hw_old = 0; hw_new = 0; ho_new = 0;
         m_off = 0; m_run = 0; m_to = 0; m_skip = 0;
         m_locked = 0; m_c0 = 0; m_c1 = 0; m_vde = 0; m_dout = 0;
         return;
      end
      // Word evaluated now: the window picked on the previous edge from the two words around it.
      win = (((hw_new << 10) | hw_old) >> ho_new) & 'h3FF;
      hw_old = hw_new;
      hw_new = w;
      ho_new = m_off;

      ctrl = 1; cv = 0;
      case (win)
         'h354: cv = 0;
         'h0AB: cv = 1;
         'h154: cv = 2;
         'h2AB: cv = 3;
         default: ctrl = 0;
      endcase
      q = ((win >> 9) & 1) ? (win ^ 'hFF) : win;
      d = q & 1;
      for (int i = 1; i < 8; i++) begin
         b = ((q >> i) ^ (q >> (i - 1))) & 1;
         if (((win >> 8) & 1) == 0) b = b ^ 1;
         d = d | (b << i);
      end

      hit = 0;
      if (m_skip > 0) m_skip--;
      else if (ctrl) begin
         if (m_run < CR) m_run++;
         hit = (m_run == CR);
      end else m_run = 0;

      wrap = (m_to == (1 << TW) - 1);
      m_to = (m_to + 1) % (1 << TW);
      if (hit) begin
         m_to = 0;
         m_locked = 1;
      end else if (wrap) begin
         m_locked = 0;
         m_off = (m_off + 1) % 10;
         m_run = 0;
         m_skip = 2;
      end

      if (!m_locked) begin
         m_vde = 0; m_dout = 0; m_c0 = 0; m_c1 = 0;
      end else if (ctrl) begin
         m_vde = 0; m_dout = 0; m_c0 = cv[0]; m_c1 = cv[1];
      end else begin
         m_vde = 1; m_dout = d;
      end
   endtask

   task automatic step(input logic [9:0] w, input logic rst);
      logic [15:0] exp;
      bus.din = w;
      rst_n   = rst;
      @(posedge pix_clk);
      model_edge(int'(w), rst);
      #1;
      exp = {m_locked, 4'(m_off), m_vde, m_c1, m_c0, 8'(m_dout)};
      chk("cycle", got, exp);
   endtask

   // Serial bit stream for the misaligned scenario, bit 0 of each word first.
   bit q_bits[$];

   task automatic push_word(input logic [9:0] w);
      for (int i = 0; i < 10; i++) q_bits.push_back(w[i]);
   endtask

   function automatic logic [9:0] pop_word();
      logic [9:0] w;
      for (int i = 0; i < 10; i++) w[i] = q_bits.pop_front();
      return w;
   endfunction

   logic [9:0] toks [4];

   initial begin
      int k_drop;
      bit seen;
      logic [9:0] rw;
      n_total = 0;
      n_bad   = 0;
      rst_n   = 1'b0;
      bus.din = '0;
      toks[0] = 10'h354; toks[1] = 10'h0AB; toks[2] = 10'h154; toks[3] = 10'h2AB;

      // Reset with random input.
      repeat (3) step(10'($urandom), 1'b0);
      chk("rst_out", got, 16'h0000);

      // Aligned lock, then two data words.
      repeat (20) step(10'h354, 1'b1);
      chk("lock_off0", {bus.locked, bus.bit_offset, bus.c1, bus.c0}, 7'b1_0000_00);
      step(10'h100, 1'b1);
      step(10'h200, 1'b1);
      step(10'h2AB, 1'b1);
      chk("data_100", {bus.vde, bus.c1, bus.c0, bus.dout}, {3'b100, 8'h00});
      step(10'h2AB, 1'b1);
      chk("data_200", {bus.vde, bus.c1, bus.c0, bus.dout}, {3'b100, 8'hFF});
      repeat (6) step(10'h2AB, 1'b1);
      chk("ctrl_11", {bus.locked, bus.vde, bus.c1, bus.c0}, 4'b1011);
      repeat (8) step(10'h0AB, 1'b1);
      chk("ctrl_01", {bus.locked, bus.vde, bus.c1, bus.c0}, 4'b1001);

      // Data only: lock must drop exactly at the timeout wrap.
      k_drop = 0;
      for (int k = 1; k <= 80; k++) begin
         step(10'h100, 1'b1);
         if (!bus.locked) begin
            k_drop = k;
            break;
         end
      end
      chk("to_drop", k_drop, 66);
      chk("slip_off", bus.bit_offset, 1);

      // Token stream delayed by 3 bits: search must settle on offset 3.
      q_bits.delete();
      repeat (3) q_bits.push_back(1'b0);
      seen = 0;
      for (int k = 0; k < 600 && !seen; k++) begin
         push_word(10'h354);
         step(pop_word(), 1'b1);
         if (bus.locked) seen = 1;
      end
      chk("shift_lock", {bus.locked, bus.bit_offset}, 5'b1_0011);
      repeat (3) begin
         push_word(10'h100);
         step(pop_word(), 1'b1);
      end
      chk("shift_data", {bus.vde, bus.dout}, 9'h100);

      // One-cycle reset while locked, then relock after CTRL_RUN tokens.
      step(10'($urandom), 1'b0);
      chk("rst_pulse", got, 16'h0000);
      for (int i = 1; i <= 8; i++) begin
         step(10'h154, 1'b1);
         if (i == 5) chk("relock_5", bus.locked, 0);
         if (i == 6) chk("relock_6", {bus.locked, bus.c1, bus.c0}, 3'b110);
      end

      // Run completion landing on the timeout wrap edge keeps lock.
      repeat (60) step(10'h100, 1'b1);
      repeat (4) step(10'h354, 1'b1);
      step(10'h100, 1'b1);
      step(10'h100, 1'b1);
      chk("wrap_tie", {bus.locked, bus.bit_offset, bus.vde, bus.c1, bus.c0}, 8'b1_0000_000);
      repeat (3) step(10'h100, 1'b1);
      chk("wrap_tie_hold", {bus.locked, bus.bit_offset, bus.vde}, 6'b1_0000_1);

      // Random mix of tokens, data and occasional resets.
      for (int i = 0; i < 600; i++) begin
         rw = ($urandom_range(0, 99) < 85) ? toks[$urandom_range(0, 3)] : 10'($urandom);
         step(rw, ($urandom_range(0, 199) != 0));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
